// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: state codes, opcodes,
// ALU-op and ALU source-B selectors.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StTrap     = 4'd9
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States that hold mem_req and are therefore subject to the wait timeout.
  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
  endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Memory wait counter: counts cycles a request goes unanswered and flags the
// cycle on which the allowed wait budget is used up.
module multicycle_control_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Expired on the MEM_TIMEOUT-th unanswered cycle; the caller still lets
  // mem_ready on that cycle win.
  assign o_expired = (r_cnt >= 16'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, register file
// and unified memory, with illegal-opcode and memory-timeout traps.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_i_or_d,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_pc_write_cond,
  output logic             o_pc_src,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic             o_reg_write,
  output logic             o_mem_to_reg,
  output logic [3:0]       o_state,
  output logic             o_illegal,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_instret
);

  state_e           r_state;
  state_e           w_state_d;
  logic             r_illegal;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_instret;

  logic w_retire;
  logic w_set_illegal;
  logic w_set_bus_err;
  logic w_expired;
  logic w_tick;
  logic w_timeout;
  logic w_clear;

  assign w_tick    = is_mem_state(r_state) && !i_mem_ready;
  assign w_timeout = w_tick && w_expired;
  // Every entry into a memory state is a state change, so clearing on any
  // transition restarts the budget for each request.
  assign w_clear   = (w_state_d != r_state);

  multicycle_control_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_clear),
    .i_tick    (w_tick),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StFetch;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_retire)      r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      StFetch: begin
        if (i_mem_ready) begin
          w_state_d = StDecode;
        end else if (w_timeout) begin
          w_state_d     = StTrap;
          w_set_bus_err = 1'b1;
        end
      end
      StDecode: begin
        case (i_opcode)
          OP_LW, OP_SW: w_state_d = StMemAddr;
          OP_R:         w_state_d = StExec;
          OP_BEQ:       w_state_d = StBranch;
          default: begin
            w_state_d     = StTrap;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        if (i_opcode == OP_LW) begin
          w_state_d = StMemRead;
        end else if (i_opcode == OP_SW) begin
          w_state_d = StMemWrite;
        end else begin
          w_state_d     = StTrap;
          w_set_illegal = 1'b1;
        end
      end
      StMemRead: begin
        if (i_mem_ready) begin
          w_state_d = StMemWb;
        end else if (w_timeout) begin
          w_state_d     = StTrap;
          w_set_bus_err = 1'b1;
        end
      end
      StMemWb: begin
        w_retire  = 1'b1;
        w_state_d = StFetch;
      end
      StMemWrite: begin
        if (i_mem_ready) begin
          w_retire  = 1'b1;
          w_state_d = StFetch;
        end else if (w_timeout) begin
          w_state_d     = StTrap;
          w_set_bus_err = 1'b1;
        end
      end
      StExec:   w_state_d = StAluWb;
      StAluWb: begin
        w_retire  = 1'b1;
        w_state_d = StFetch;
      end
      StBranch: begin
        w_retire  = 1'b1;
        w_state_d = StFetch;
      end
      StTrap:   w_state_d = StTrap;
      default:  w_state_d = StTrap;
    endcase
  end

  // Gated by reset so mem_req drops the moment rst_n falls, even though the
  // reset state (FETCH) would otherwise request.
  always_comb begin
    o_mem_req       = 1'b0;
    o_mem_we        = 1'b0;
    o_i_or_d        = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_pc_src        = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_REG;
    o_alu_op        = ALUOP_ADD;
    o_reg_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        StFetch: begin
          o_mem_req   = 1'b1;
          o_alu_src_b = SRCB_FOUR;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        StDecode: o_alu_src_b = SRCB_IMM;
        StMemAddr: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = SRCB_IMM;
        end
        StMemRead: begin
          o_mem_req = 1'b1;
          o_i_or_d  = 1'b1;
        end
        StMemWb: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
        end
        StMemWrite: begin
          o_mem_req = 1'b1;
          o_mem_we  = 1'b1;
          o_i_or_d  = 1'b1;
        end
        StExec: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = ALUOP_FUNC;
        end
        StAluWb: o_reg_write = 1'b1;
        StBranch: begin
          o_alu_src_a     = 1'b1;
          o_alu_op        = ALUOP_SUB;
          o_pc_write_cond = 1'b1;
          o_pc_src        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_illegal = r_illegal;
  assign o_bus_err = r_bus_err;
  assign o_instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level model of the
// expected per-cycle control word, checked every cycle plus literal spot checks.
module tb_multicycle_control;

  localparam int unsigned T  = 4;
  localparam int unsigned CW = 8;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MADDR = 2, P_MREAD = 3, P_MWB = 4;
  localparam int P_MWRITE = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_TRAP = 9;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011, ADDI = 7'b0010011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src;
  logic          alu_src_a, reg_write, mem_to_reg, illegal, bus_err;
  logic [1:0]    alu_src_b, alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_control #(
    .MEM_TIMEOUT (T),
    .CNT_W       (CW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_opcode        (opcode),
    .i_zero          (zero),
    .i_mem_ready     (mem_ready),
    .o_mem_req       (mem_req),
    .o_mem_we        (mem_we),
    .o_i_or_d        (i_or_d),
    .o_ir_write      (ir_write),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_pc_src        (pc_src),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_reg_write     (reg_write),
    .o_mem_to_reg    (mem_to_reg),
    .o_state         (state),
    .o_illegal       (illegal),
    .o_bus_err       (bus_err),
    .o_instret       (instret)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b, alu_op;
    logic          reg_write, mem_to_reg, illegal, bus_err;
    logic [CW-1:0] instret;
  } vec_t;

  vec_t got, exp_v;
  bit   exp_on = 1'b0;
  int   total = 0, bad = 0;
  int   m_instret = 0;
  bit   m_ill = 1'b0, m_be = 1'b0;

  assign got = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal, bus_err, instret};

  // Control word each phase must present, straight from the phase descriptions.
  function automatic vec_t micro(int st, bit rdy);
    vec_t v = '0;
    v.st = st[3:0];
    case (st)
      P_FETCH:  begin v.mem_req = 1; v.alu_src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy; end
      P_DECODE: v.alu_src_b = 2'b10;
      P_MADDR:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      P_MREAD:  begin v.mem_req = 1; v.i_or_d = 1; end
      P_MWB:    begin v.reg_write = 1; v.mem_to_reg = 1; end
      P_MWRITE: begin v.mem_req = 1; v.mem_we = 1; v.i_or_d = 1; end
      P_EXEC:   begin v.alu_src_a = 1; v.alu_op = 2'b10; end
      P_ALUWB:  v.reg_write = 1;
      P_BRANCH: begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_write_cond = 1; v.pc_src = 1; end
      default:  ;
    endcase
    v.illegal = m_ill;
    v.bus_err = m_be;
    v.instret = m_instret[CW-1:0];
    return v;
  endfunction

  always @(negedge clk) begin
    if (exp_on) begin
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, got, exp_v);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // One cycle of a phase; model counters update after the edge that ends it.
  task automatic cyc(int st, bit rdy, bit ret = 0, bit ill = 0, bit be = 0);
    mem_ready = rdy;
    exp_v     = micro(st, rdy);
    exp_on    = 1'b1;
    @(posedge clk);
    #1;
    if (ret) m_instret = (m_instret + 1) % (1 << CW);
    if (ill) m_ill = 1'b1;
    if (be)  m_be = 1'b1;
  endtask

  task automatic mem_phase(int st, int w, bit ret, output bit ok);
    if (w >= int'(T)) begin
      for (int i = 0; i < int'(T) - 1; i++) cyc(st, 0);
      cyc(st, 0, 0, 0, 1);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < w; i++) cyc(st, 0);
      cyc(st, 1, ret);
      ok = 1'b1;
    end
  endtask

  task automatic fetch(int w);
    bit ok;
    mem_phase(P_FETCH, w, 0, ok);
  endtask

  task automatic do_lw(int fw, int rw);
    bit ok;
    opcode = LW;
    fetch(fw);
    cyc(P_DECODE, 0);
    cyc(P_MADDR, 0);
    mem_phase(P_MREAD, rw, 0, ok);
    if (ok) cyc(P_MWB, 0, 1);
  endtask

  task automatic do_sw(int fw, int ww);
    bit ok;
    opcode = SW;
    fetch(fw);
    cyc(P_DECODE, 0);
    cyc(P_MADDR, 0);
    mem_phase(P_MWRITE, ww, 1, ok);
  endtask

  task automatic do_r(int fw);
    opcode = RT;
    fetch(fw);
    cyc(P_DECODE, 0);
    cyc(P_EXEC, 0);
    cyc(P_ALUWB, 0, 1);
  endtask

  task automatic do_beq(int fw, bit z);
    opcode = BEQ;
    zero   = z;
    fetch(fw);
    cyc(P_DECODE, 1);
    cyc(P_BRANCH, 1, 1);
  endtask

  task automatic trap_cycles(int n);
    for (int i = 0; i < n; i++) cyc(P_TRAP, i[0]);
  endtask

  task automatic do_reset();
    exp_on    = 1'b0;
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_instret", 32'(instret), 0);
    chk("rst_sticky", {30'd0, illegal, bus_err}, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    m_instret = 0;
    m_ill     = 1'b0;
    m_be      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #12;
    chk("reset_state", 32'(state), 0);
    chk("reset_strobes", {28'd0, mem_req, mem_we, ir_write, pc_write}, 0);
    chk("reset_counters", {22'd0, illegal, bus_err, instret}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_lw(0, 0);
    chk("lw_instret", 32'(instret), 1);
    do_r(0);
    chk("r_instret", 32'(instret), 2);
    do_beq(0, 1);
    do_beq(0, 0);
    chk("beq_instret", 32'(instret), 4);
    do_sw(0, 3);               // ready on the last allowed wait cycle wins
    chk("sw_no_bus_err", 32'(bus_err), 0);
    chk("sw_instret", 32'(instret), 5);
    do_lw(2, 3);
    chk("lw_wait_instret", 32'(instret), 6);
    for (int i = 0; i < 250; i++) do_beq(i % 2, i[0]);
    chk("instret_wrap", 32'(instret), 0);

    opcode = LW;
    fetch(int'(T));            // fetch never answered
    trap_cycles(5);
    chk("timeout_bus_err", 32'(bus_err), 1);
    chk("timeout_state", 32'(state), 9);
    chk("timeout_mem_req", 32'(mem_req), 0);

    do_reset();
    opcode = ADDI;
    fetch(0);
    cyc(P_DECODE, 0, 0, 1);
    trap_cycles(3);
    chk("illegal_flag", 32'(illegal), 1);
    chk("illegal_state", 32'(state), 9);

    do_reset();
    do_r(1);
    opcode = LW;
    fetch(0);
    cyc(P_DECODE, 0);
    cyc(P_MADDR, 0);
    cyc(P_MREAD, 0);
    chk("mid_read_req", 32'(mem_req), 1);
    exp_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_state", 32'(state), 0);
    chk("abort_instret", 32'(instret), 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    m_instret = 0;
    do_r(0);
    chk("after_abort_instret", 32'(instret), 1);

    exp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
